// File: rtl/vend_pkg.sv
// Shared definitions for the stock ledger.
//   state_e    : ledger FSM state encoding
//   StockMax   : ceiling for per-aisle stock and sold counts
//   SumMax     : ceiling for the saturating sales total
//   is_onehot  : true when exactly one aisle select bit is set
package vend_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StVend,
        StReject,
        StRefill
    } state_e;

    localparam logic [7:0] StockMax = 8'd99;
    localparam logic [7:0] SumMax   = 8'd255;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/sat_inc.sv
// Saturating 8-bit adder.
//   a, inc : operands
//   sum    : a + inc, clamped to Limit when SatEn is set, otherwise modulo 256
module sat_inc #(
    parameter logic [7:0] Limit = 8'd255,
    parameter bit         SatEn = 1'b1
) (
    input  logic [7:0] a,
    input  logic [7:0] inc,
    output logic [7:0] sum
);

    logic [8:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, inc};
        if (SatEn && (full > {1'b0, Limit})) begin
            sum = Limit;
        end else begin
            sum = full[7:0];
        end
    end

endmodule

// File: rtl/stock_ledger.sv
// Four-aisle vending stock ledger.
//   clk, rst (async, active-low)
//   sel         : one-hot aisle select (bit0 = aisle 1)
//   buy         : purchase request pulse, accepted only when idle
//   refill_mode : replenishment mode level
//   add         : in refill mode, add one unit to the selected aisle
//   s1..s4      : stock per aisle       sl1..sl4 : units sold per aisle
//   price_sum   : cumulative sales total
//   flag        : selected aisle full while refilling
//   vend_ok/vend_err : purchase result pulses     busy : FSM not idle
// Build option: define SALES_SAT_EN to saturate price_sum at 255 instead of wrapping.
module stock_ledger
    import vend_pkg::*;
#(
    parameter logic [7:0] PRICE1     = 8'd3,
    parameter logic [7:0] PRICE2     = 8'd5,
    parameter logic [7:0] PRICE3     = 8'd7,
    parameter logic [7:0] PRICE4     = 8'd9,
    parameter logic [7:0] INIT_STOCK = 8'd10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sel,
    input  logic       buy,
    input  logic       refill_mode,
    input  logic       add,
    output logic [7:0] s1,
    output logic [7:0] s2,
    output logic [7:0] s3,
    output logic [7:0] s4,
    output logic [7:0] sl1,
    output logic [7:0] sl2,
    output logic [7:0] sl3,
    output logic [7:0] sl4,
    output logic [7:0] price_sum,
    output logic       flag,
    output logic       vend_ok,
    output logic       vend_err,
    output logic       busy
);

`ifdef SALES_SAT_EN
    localparam bit SumSat = 1'b1;
`else
    localparam bit SumSat = 1'b0;
`endif

    state_e          state_q, state_d;
    logic [3:0]      sel_q, sel_d;
    logic [3:0][7:0] stock_q, stock_d;
    logic [3:0][7:0] sold_q, sold_d;
    logic [7:0]      sum_q, sum_d;
    logic            flag_q, flag_d;
    logic            ok_q, ok_d;
    logic            err_q, err_d;

    logic [3:0][7:0] stock_inc, sold_inc;
    logic [7:0]      sum_add, price_sel, stock_latched, stock_live;

    for (genvar i = 0; i < 4; i++) begin : g_aisle
        sat_inc #(.Limit(StockMax), .SatEn(1'b1)) u_stock_inc (
            .a   (stock_q[i]),
            .inc (8'd1),
            .sum (stock_inc[i])
        );
        sat_inc #(.Limit(StockMax), .SatEn(1'b1)) u_sold_inc (
            .a   (sold_q[i]),
            .inc (8'd1),
            .sum (sold_inc[i])
        );
    end

    sat_inc #(.Limit(SumMax), .SatEn(SumSat)) u_sum_add (
        .a   (sum_q),
        .inc (price_sel),
        .sum (sum_add)
    );

    always_comb begin
        price_sel = 8'd0;
        unique case (sel_q)
            4'b0001: price_sel = PRICE1;
            4'b0010: price_sel = PRICE2;
            4'b0100: price_sel = PRICE3;
            4'b1000: price_sel = PRICE4;
            default: price_sel = 8'd0;
        endcase
    end

    // OR-select is exact for one-hot selects; non-one-hot cases are rejected separately.
    always_comb begin
        stock_latched = 8'd0;
        stock_live    = 8'd0;
        for (int i = 0; i < 4; i++) begin
            if (sel_q[i]) stock_latched = stock_latched | stock_q[i];
            if (sel[i])   stock_live    = stock_live | stock_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        stock_d = stock_q;
        sold_d  = sold_q;
        sum_d   = sum_q;
        flag_d  = 1'b0;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (refill_mode) begin
                    state_d = StRefill;
                end else if (buy) begin
                    state_d = StCheck;
                    sel_d   = sel;
                end
            end
            StCheck: begin
                if (!is_onehot(sel_q) || (stock_latched == 8'd0)) begin
                    state_d = StReject;
                end else begin
                    state_d = StVend;
                end
            end
            StVend: begin
                for (int i = 0; i < 4; i++) begin
                    if (sel_q[i]) begin
                        stock_d[i] = stock_q[i] - 8'd1;
                        sold_d[i]  = sold_inc[i];
                    end
                end
                sum_d   = sum_add;
                ok_d    = 1'b1;
                state_d = StIdle;
            end
            StReject: begin
                err_d   = 1'b1;
                state_d = StIdle;
            end
            StRefill: begin
                if (!refill_mode) begin
                    state_d = StIdle;
                end else begin
                    if (add && is_onehot(sel)) begin
                        for (int i = 0; i < 4; i++) begin
                            if (sel[i]) stock_d[i] = stock_inc[i];
                        end
                    end
                    flag_d = is_onehot(sel) && (stock_live == StockMax);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            sel_q   <= 4'd0;
            stock_q <= {4{INIT_STOCK}};
            sold_q  <= '0;
            sum_q   <= 8'd0;
            flag_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            stock_q <= stock_d;
            sold_q  <= sold_d;
            sum_q   <= sum_d;
            flag_q  <= flag_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    assign s1        = stock_q[0];
    assign s2        = stock_q[1];
    assign s3        = stock_q[2];
    assign s4        = stock_q[3];
    assign sl1       = sold_q[0];
    assign sl2       = sold_q[1];
    assign sl3       = sold_q[2];
    assign sl4       = sold_q[3];
    assign price_sum = sum_q;
    assign flag      = flag_q;
    assign vend_ok   = ok_q;
    assign vend_err  = err_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_stock_ledger.sv
// Scoreboard bench for stock_ledger: directed scenarios plus randomized traffic,
// checked against a behavioural ledger model kept in plain integer arrays.
module tb_stock_ledger;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] sel = 4'd0;
    logic       buy = 1'b0;
    logic       refill_mode = 1'b0;
    logic       add = 1'b0;
    logic [7:0] s1, s2, s3, s4, sl1, sl2, sl3, sl4, price_sum;
    logic       flag, vend_ok, vend_err, busy;

    stock_ledger dut (
        .clk         (clk),
        .rst         (rst),
        .sel         (sel),
        .buy         (buy),
        .refill_mode (refill_mode),
        .add         (add),
        .s1          (s1),
        .s2          (s2),
        .s3          (s3),
        .s4          (s4),
        .sl1         (sl1),
        .sl2         (sl2),
        .sl3         (sl3),
        .sl4         (sl4),
        .price_sum   (price_sum),
        .flag        (flag),
        .vend_ok     (vend_ok),
        .vend_err    (vend_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    logic [3:0][7:0] st_vec, sl_vec;
    assign st_vec = {s4, s3, s2, s1};
    assign sl_vec = {sl4, sl3, sl2, sl1};

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        bit              ok;
        int              n;
        logic [3:0][7:0] st;
        logic [3:0][7:0] sl;
        logic [7:0]      sum;
    } exp_t;

    exp_t q[$];

    // Reference ledger
    int m_st[4];
    int m_sl[4];
    int m_sum;

    function automatic int price(int a);
        case (a)
            0: return 3;
            1: return 5;
            2: return 7;
            default: return 9;
        endcase
    endfunction

    function automatic bit onehot(logic [3:0] v);
        return $countones(v) == 1;
    endfunction

    function automatic int aisle(logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_st[i] = 10;
            m_sl[i] = 0;
        end
        m_sum = 0;
    endtask

    function automatic exp_t snap(bit ok, int n);
        exp_t e;
        e.ok = ok;
        e.n  = n;
        for (int i = 0; i < 4; i++) begin
            e.st[i] = m_st[i][7:0];
            e.sl[i] = m_sl[i][7:0];
        end
        e.sum = m_sum[7:0];
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_s%0d", tag, i + 1), st_vec[i], m_st[i]);
            chk($sformatf("%s_sl%0d", tag, i + 1), sl_vec[i], m_sl[i]);
        end
        chk({tag, "_price_sum"}, price_sum, m_sum);
    endtask

    // Monitor: every result pulse is matched against the oldest pending purchase.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (vend_ok || vend_err) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: vend_ok=%0b vend_err=%0b, expected no pulse",
                         vend_ok, vend_err);
            end else begin
                e = q.pop_front();
                chk("result_ok", vend_ok, e.ok);
                chk("result_err", vend_err, !e.ok);
                chk("result_latency_edge", cyc, e.n + 2);
                for (int i = 0; i < 4; i++) begin
                    chk($sformatf("result_s%0d", i + 1), st_vec[i], e.st[i]);
                    chk($sformatf("result_sl%0d", i + 1), sl_vec[i], e.sl[i]);
                end
                chk("result_price_sum", price_sum, e.sum);
            end
        end
    end

    // All stimulus tasks are entered and left at a falling edge.
    task automatic wait_idle();
        int k = 0;
        while (busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout: busy=%0b, expected 0", busy);
        end
    endtask

    task automatic do_buy(logic [3:0] sel_v, bit add_v, bit twice);
        bit ok;
        int a;
        int k;
        wait_idle();
        a  = aisle(sel_v);
        ok = onehot(sel_v) && (m_st[a] > 0);
        if (ok) begin
            m_st[a] -= 1;
            m_sl[a] = (m_sl[a] + 1 > 99) ? 99 : m_sl[a] + 1;
`ifdef SALES_SAT_EN
            m_sum = (m_sum + price(a) > 255) ? 255 : m_sum + price(a);
`else
            m_sum = (m_sum + price(a)) % 256;
`endif
        end
        q.push_back(snap(ok, cyc + 1));
        sel = sel_v;
        buy = 1'b1;
        add = add_v;
        @(negedge clk);
        buy = 1'b0;
        add = 1'b0;
        sel = 4'($urandom_range(0, 15));
        if (twice) begin
            buy = 1'b1;
            @(negedge clk);
            buy = 1'b0;
        end
        k = 0;
        while (q.size() != 0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: %0d results pending, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic refill(logic [3:0] sel_v, int n, bit noise);
        int a;
        wait_idle();
        refill_mode = 1'b1;
        @(negedge clk);
        chk("refill_busy", busy, 1);
        a = aisle(sel_v);
        for (int i = 0; i < n; i++) begin
            sel = sel_v;
            add = 1'b1;
            buy = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (onehot(sel_v)) m_st[a] = (m_st[a] + 1 > 99) ? 99 : m_st[a] + 1;
            @(negedge clk);
            add = 1'b0;
            buy = 1'b0;
            @(negedge clk);
        end
        @(negedge clk);
        chk("refill_flag", flag, onehot(sel_v) && (m_st[a] == 99));
        refill_mode = 1'b0;
        @(negedge clk);
        chk("refill_exit_flag", flag, 0);
        chk("refill_exit_busy", busy, 0);
        check_all("refill");
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b0;
        #1;
        model_reset();
        q.delete();
        check_all("rst");
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        chk("reset_flag", flag, 0);
        chk("reset_vend_ok", vend_ok, 0);
        chk("reset_vend_err", vend_err, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b1;

        // First buy straight out of reset
        do_buy(4'b0001, 1'b0, 1'b0);
        chk("first_s1", s1, 9);
        chk("first_sl1", sl1, 1);
        chk("first_price_sum", price_sum, 3);

        // Drain aisle 2, then buy from it once more
        for (int i = 0; i < 10; i++) do_buy(4'b0010, 1'b0, 1'b0);
        do_buy(4'b0010, 1'b0, 1'b0);
        chk("drain_s2", s2, 0);
        chk("drain_sl2", sl2, 10);
        chk("drain_price_sum", price_sum, 53);

        // Non-one-hot select is rejected
        do_buy(4'b0011, 1'b0, 1'b0);
        check_all("multi_sel");

        // Second buy while busy is dropped; add alongside buy outside refill is ignored
        do_buy(4'b0001, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        do_buy(4'b0100, 1'b1, 1'b0);
        check_all("buy_add");

        // Fill aisle 3 to its ceiling
        refill(4'b0100, 95, 1'b0);
        chk("fill_s3", s3, 99);

        // Sales total overflow on aisle 4
        pulse_reset();
        refill(4'b1000, 19, 1'b0);
        for (int i = 0; i < 29; i++) do_buy(4'b1000, 1'b0, 1'b0);
`ifdef SALES_SAT_EN
        chk("overflow_price_sum", price_sum, 255);
`else
        chk("overflow_price_sum", price_sum, 5);
`endif
        chk("overflow_sl4", sl4, 29);

        // Reset during VEND: no result pulse, everything back to reset values
        wait_idle();
        sel = 4'b0001;
        buy = 1'b1;
        @(negedge clk);
        buy = 1'b0;
        @(posedge clk);
        #1;
        chk("midvend_busy", busy, 1);
        rst = 1'b0;
        #1;
        model_reset();
        check_all("midvend_rst");
        chk("midvend_vend_ok", vend_ok, 0);
        chk("midvend_busy_rst", busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check_all("midvend_after");

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            int r;
            logic [3:0] s;
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 4) == 0) s = 4'($urandom_range(0, 15));
            else s = 4'(1 << $urandom_range(0, 3));
            if (r < 2) refill(s, $urandom_range(1, 6), 1'b1);
            else do_buy(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        repeat (4) @(negedge clk);
        check_all("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stock_ledger.md
STOCK_LEDGER -- requirements
Module: stock_ledger

Interface
REQ-001 The block SHALL have parameter PRICE1, default 8'd3, unit price of aisle 1 in currency units.
REQ-002 The block SHALL have parameters PRICE2 (default 8'd5), PRICE3 (default 8'd7) and PRICE4 (default 8'd9), the unit prices of aisles 2-4.
REQ-003 The block SHALL have parameter INIT_STOCK, default 8'd10, the per-aisle stock loaded at reset, legal range 0-99.
REQ-004 The block SHALL have clk, input, 1, system clock.
REQ-005 The block SHALL have rst, input, 1, reset; asynchronous, active-low.
REQ-006 The block SHALL have sel, input, 4, aisle select, one-hot, bit0 = aisle 1.
REQ-007 The block SHALL have buy, input, 1, single-cycle purchase request pulse.
REQ-008 The block SHALL have refill_mode, input, 1, replenishment mode level.
REQ-009 The block SHALL have add, input, 1, single-cycle pulse that adds one unit to the selected aisle.
REQ-010 The block SHALL have s1..s4, output, 8 each, current stock per aisle (0-99).
REQ-011 The block SHALL have sl1..sl4, output, 8 each, units sold per aisle (0-99).
REQ-012 The block SHALL have price_sum, output, 8, cumulative sales total.
REQ-013 The block SHALL have flag, output, 1, set when the selected aisle is full in refill mode.
REQ-014 The block SHALL have vend_ok and vend_err, output, 1 each, single-cycle purchase result pulses.
REQ-015 The block SHALL have busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, CHECK, VEND, REJECT and REFILL.
REQ-017 In IDLE with refill_mode=0, a buy pulse SHALL move the FSM to CHECK on the next edge and latch sel.
REQ-018 In CHECK, a latched sel that is not one-hot, or selects an aisle with stock 0, SHALL go to REJECT; otherwise the FSM SHALL go to VEND.
REQ-019 VEND SHALL, in one edge, decrement the stock, increment the sold count (saturating at 99) and add the price to price_sum; it SHALL pulse vend_ok and return to IDLE.
REQ-020 REJECT SHALL pulse vend_err for one cycle, leave all counters unchanged, and return to IDLE.
REQ-021 Buy-to-result latency SHALL be fixed: with buy sampled at edge N, vend_ok or vend_err is high in the cycle after edge N+2, and counters update at edge N+2.
REQ-022 A buy pulse received while busy=1 SHALL be dropped.
REQ-023 refill_mode=1 in IDLE SHALL move the FSM to REFILL.
REQ-024 refill_mode=0 in REFILL SHALL return the FSM to IDLE and clear flag.
REQ-025 In REFILL, buy SHALL be ignored.
REQ-026 In REFILL, add with a one-hot sel SHALL increment that aisle's stock by 1, saturating at 99.
REQ-027 In REFILL, add with a non-one-hot sel SHALL be ignored.
REQ-028 In REFILL, flag SHALL be registered and equal (stock of the selected aisle == 99), updated every cycle; flag SHALL be 0 outside REFILL.
REQ-029 If buy and add arrive in the same cycle, only the one matching refill_mode SHALL take effect.
REQ-030 Whether price_sum saturates or wraps on overflow SHALL follow REQ-033.

Reset
REQ-031 Asserting rst at any time, including mid-VEND, SHALL force IDLE, s1..s4=INIT_STOCK, sl1..sl4=0, price_sum=0, and flag, vend_ok, vend_err, busy=0.
REQ-032 After rst deasserts, the first buy SHALL be accepted on the first clk edge.

Configuration
REQ-033 With SALES_SAT_EN defined, price_sum SHALL saturate at 255; without it, price_sum SHALL wrap modulo 256.

Structure
REQ-034 The state encoding and the 99 stock limit SHALL be defined in the shared package vend_pkg.
REQ-035 One sub-module, sat_inc (a saturating 8-bit adder with a parameterised limit), SHALL be used for stock, sold count and price_sum.

Verification
REQ-036 Reset then buy with sel=0001 -> vend_ok 3 cycles later, s1=9, sl1=1, price_sum=3.
REQ-037 Drain aisle 2 to 0, then buy with sel=0010 -> vend_err pulse; s2=0, sl2=10 and price_sum unchanged.
REQ-038 buy with sel=0011 -> vend_err; all counters unchanged.
REQ-039 refill_mode=1, sel=0100, 95 add pulses -> s3 saturates at 99, flag=1; refill_mode=0 -> flag=0.
REQ-040 29 buys on aisle 4 after refills, reaching 261 total -> price_sum=255 with SALES_SAT_EN, or 5 without it.
REQ-041 Assert rst in the VEND cycle -> all outputs return to reset values and no vend_ok pulse occurs.
